// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    CONV_RST,
    EXPOSE,
    CONV_SIG,
    READ
  } seq_state_t;

  function automatic int ramp_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  localparam int COUNTER_WIDTH = 8;
  localparam int RAMP_MAX = ramp_max(COUNTER_WIDTH);

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster row/column address counter for frame readout.
module pixel_scan_counter #(
  parameter int array_width  = 10,
  parameter int array_height = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            step,
  output logic [$clog2(array_height)-1:0] row_sel,
  output logic [$clog2(array_width)-1:0]  col_sel,
  output logic                            last
);

  localparam int RW = $clog2(array_height);
  localparam int CW = $clog2(array_width);
  localparam logic [RW-1:0] ROW_LAST = RW'(array_height - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(array_width - 1);

  logic col_end;

  assign col_end = (col_sel == COL_LAST);
  assign last    = col_end && (row_sel == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sel <= '0;
      col_sel <= '0;
    end else if (clear) begin
      row_sel <= '0;
      col_sel <= '0;
    end else if (step) begin
      if (col_end) begin
        col_sel <= '0;
        row_sel <= last ? '0 : row_sel + RW'(1);
      end else begin
        col_sel <= col_sel + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Frame controller: erase, optional CDS reset conversion, exposure,
// signal conversion and raster readout.
module pixel_sequencer
  import pixel_ctrl_pkg::*;
#(
  parameter int array_width     = 10,
  parameter int array_height    = 10,
  parameter int counter_width   = 8,
  parameter int erase_cycles    = 5,
  parameter int exposure_cycles = 255
) (
  input  logic                            system_clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            cont_mode,
  input  logic                            cds,
  output logic                            erase,
  output logic                            expose,
  output logic                            convert,
  output logic                            conv_phase,
  output logic [counter_width-1:0]        ramp,
  output logic                            read,
  output logic [$clog2(array_height)-1:0] row_sel,
  output logic [$clog2(array_width)-1:0]  col_sel,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int PMAX = (erase_cycles > exposure_cycles) ?
                        erase_cycles : exposure_cycles;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [PW-1:0] E_LAST = PW'(erase_cycles - 1);
  localparam logic [PW-1:0] X_LAST = PW'(exposure_cycles - 1);
  localparam logic [counter_width-1:0] RMAX =
    counter_width'(ramp_max(counter_width));

  seq_state_t    state;
  logic [PW-1:0] cnt;
  logic          cont_l;
  logic          cds_l;
  logic          last;

  pixel_scan_counter #(
    .array_width (array_width),
    .array_height(array_height)
  ) u_scan (
    .clk    (system_clk),
    .reset  (reset),
    .clear  (state != READ),
    .step   (state == READ),
    .row_sel(row_sel),
    .col_sel(col_sel),
    .last   (last)
  );

  // Strobes default low each cycle; each branch re-asserts the strobe
  // of the state that will be current after this edge.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cont_l     <= 1'b0;
      cds_l      <= 1'b0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      conv_phase <= 1'b0;
      ramp       <= '0;
      read       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      conv_phase <= 1'b0;
      read       <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state  <= ERASE;
            erase  <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            cont_l <= cont_mode;
            cds_l  <= cds;
          end
        end
        ERASE: begin
          if (cnt == E_LAST) begin
            cnt <= '0;
            if (cds_l) begin
              state   <= CONV_RST;
              convert <= 1'b1;
            end else begin
              state  <= EXPOSE;
              expose <= 1'b1;
            end
          end else begin
            cnt   <= cnt + PW'(1);
            erase <= 1'b1;
          end
        end
        CONV_RST: begin
          if (ramp == RMAX) begin
            ramp   <= '0;
            state  <= EXPOSE;
            expose <= 1'b1;
          end else begin
            ramp    <= ramp + counter_width'(1);
            convert <= 1'b1;
          end
        end
        EXPOSE: begin
          if (cnt == X_LAST) begin
            cnt        <= '0;
            state      <= CONV_SIG;
            convert    <= 1'b1;
            conv_phase <= 1'b1;
          end else begin
            cnt    <= cnt + PW'(1);
            expose <= 1'b1;
          end
        end
        CONV_SIG: begin
          if (ramp == RMAX) begin
            ramp  <= '0;
            state <= READ;
            read  <= 1'b1;
          end else begin
            ramp       <= ramp + counter_width'(1);
            convert    <= 1'b1;
            conv_phase <= 1'b1;
          end
        end
        READ: begin
          if (last) begin
            frame_done <= 1'b1;
            if (cont_l && enable) begin
              state  <= ERASE;
              erase  <= 1'b1;
              cont_l <= cont_mode;
              cds_l  <= cds;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            read <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: per-cycle scoreboard on the
// default build plus a table of frame measurements on a small build.
module tb_pixel_sequencer;

  localparam int W = 10;
  localparam int H = 10;
  localparam int E = 5;
  localparam int X = 255;
  localparam int N = 256;
  localparam int P = W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cont_mode = 1'b0;
  logic cds = 1'b0;

  logic       erase, expose, convert, conv_phase, read, busy, frame_done;
  logic [7:0] ramp;
  logic [3:0] row_sel, col_sel;

  logic       s_enable = 1'b0;
  logic       s_cont = 1'b0;
  logic       s_cds = 1'b0;
  logic       s_erase, s_expose, s_convert, s_phase, s_read;
  logic       s_busy, s_done;
  logic [3:0] s_ramp;
  logic       s_row;
  logic [1:0] s_col;

  pixel_sequencer dut (
    .system_clk(clk),
    .reset     (reset),
    .enable    (enable),
    .cont_mode (cont_mode),
    .cds       (cds),
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .conv_phase(conv_phase),
    .ramp      (ramp),
    .read      (read),
    .row_sel   (row_sel),
    .col_sel   (col_sel),
    .busy      (busy),
    .frame_done(frame_done)
  );

  pixel_sequencer #(
    .array_width    (3),
    .array_height   (2),
    .counter_width  (4),
    .erase_cycles   (2),
    .exposure_cycles(3)
  ) dut_s (
    .system_clk(clk),
    .reset     (reset),
    .enable    (s_enable),
    .cont_mode (s_cont),
    .cds       (s_cds),
    .erase     (s_erase),
    .expose    (s_expose),
    .convert   (s_convert),
    .conv_phase(s_phase),
    .ramp      (s_ramp),
    .read      (s_read),
    .row_sel   (s_row),
    .col_sel   (s_col),
    .busy      (s_busy),
    .frame_done(s_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int start;
    bit cds;
  } frame_t;

  frame_t exp_q[$];
  int     done_q[$];

  typedef struct {
    bit cds;
    bit cont;
    int len;
    int nread;
    int nconv;
    int nerase;
    int nexp;
    int maxr;
  } vec_t;

  logic [22:0] act;
  assign act = {erase, expose, convert, conv_phase, read, busy,
                frame_done, ramp, row_sel, col_sel};

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  function automatic int frame_len(input bit c);
    return E + (c ? N : 0) + X + N + P;
  endfunction

  // Expected output word t cycles after the frame's first erase cycle.
  function automatic logic [22:0] frame_out(input int t, input bit c);
    logic [22:0] o;
    int r0, x0, s0, ln;
    o  = '0;
    r0 = E + (c ? N : 0);
    x0 = r0 + X;
    s0 = x0 + N;
    ln = s0 + P;
    if (t < E) begin
      o[22] = 1'b1;
    end else if (t < r0) begin
      o[20]    = 1'b1;
      o[15:8]  = 8'(t - E);
    end else if (t < x0) begin
      o[21] = 1'b1;
    end else if (t < s0) begin
      o[20]   = 1'b1;
      o[19]   = 1'b1;
      o[15:8] = 8'(t - x0);
    end else if (t < ln) begin
      o[18]  = 1'b1;
      o[7:4] = 4'((t - s0) / W);
      o[3:0] = 4'((t - s0) % W);
    end
    if (t < ln) o[17] = 1'b1;
    return o;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      logic [22:0] e;
      e = '0;
      if (exp_q.size() > 0 &&
          cyc - exp_q[0].start == frame_len(exp_q[0].cds)) begin
        e[16] = 1'b1;
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && cyc >= exp_q[0].start)
        e = e | frame_out(cyc - exp_q[0].start, exp_q[0].cds);
      if (frame_done) done_q.push_back(cyc);
      check($sformatf("cycle %0d outputs", cyc), 32'(act), 32'(e));
    end
  end

  task automatic start_frame(input bit c, input bit co, input bit hold,
                             output int s);
    cds       = c;
    cont_mode = co;
    enable    = 1'b1;
    s         = cyc + 1;
    exp_q.push_back('{start: s, cds: c});
    tick();
    if (!hold) enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[3];
    int   s, s2;
    tbl[0] = '{cds: 1, cont: 0, len: 43, nread: 6, nconv: 32,
               nerase: 2, nexp: 3, maxr: 15};
    tbl[1] = '{cds: 0, cont: 0, len: 27, nread: 6, nconv: 16,
               nerase: 2, nexp: 3, maxr: 15};
    tbl[2] = '{cds: 1, cont: 1, len: 43, nread: 6, nconv: 32,
               nerase: 2, nexp: 3, maxr: 15};

    repeat (3) tick();
    check("reset outputs", 32'(act), 32'h0);
    check("reset small busy", 32'({s_busy, s_erase, s_ramp}), 32'h0);
    mon_on = 1'b1;
    reset  = 1'b0;
    repeat (2) tick();

    // single frame with CDS, then without
    start_frame(1'b1, 1'b0, 1'b0, s);
    wait_until(s + 880);
    start_frame(1'b0, 1'b0, 1'b0, s);
    wait_until(s + 625);

    // continuous: three frames, enable dropped inside the third
    done_q.delete();
    start_frame(1'b1, 1'b1, 1'b1, s);
    exp_q.push_back('{start: s + 872, cds: 1'b1});
    exp_q.push_back('{start: s + 1744, cds: 1'b1});
    wait_until(s + 1744 + 400);
    enable = 1'b0;
    wait_until(s + 2616 + 5);
    check("cont done count", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("cont spacing 1", 32'(done_q[1] - done_q[0]), 32'd872);
      check("cont spacing 2", 32'(done_q[2] - done_q[1]), 32'd872);
    end

    // mode inputs toggled during exposure only affect the next frame
    start_frame(1'b1, 1'b0, 1'b1, s);
    wait_until(s + E + N + 100);
    cds       = 1'b0;
    cont_mode = 1'b1;
    s2        = s + 873;
    exp_q.push_back('{start: s2, cds: 1'b0});
    wait_until(s2 + 300);
    enable = 1'b0;
    wait_until(s2 + 616 + 5);

    // asynchronous reset in the middle of readout at pixel (4,7)
    start_frame(1'b1, 1'b0, 1'b0, s);
    wait_until(s + E + N + X + N + 47);
    check("pre-reset row", 32'(row_sel), 32'd4);
    check("pre-reset col", 32'(col_sel), 32'd7);
    check("pre-reset read", 32'(read), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async reset outputs", 32'(act), 32'h0);
    cds       = 1'b0;
    cont_mode = 1'b0;
    enable    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    s     = cyc + 1;
    exp_q.push_back('{start: s, cds: 1'b0});
    tick();
    enable = 1'b0;
    wait_until(s + 625);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // small build: frame measurements from a table
    for (int v = 0; v < 3; v++) begin
      int  len, nread, nconv, nerase, nexp, maxr;
      int  prow, pcol;
      bit  have, wrap;
      logic busy_at_done;
      len = -1; nread = 0; nconv = 0; nerase = 0; nexp = 0; maxr = 0;
      have = 1'b0; wrap = 1'b0; prow = 0; pcol = 0;
      busy_at_done = 1'bx;
      s_cds    = tbl[v].cds;
      s_cont   = tbl[v].cont;
      s_enable = 1'b1;
      @(posedge clk);
      #1;
      s_enable = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (s_erase) nerase++;
        if (s_expose) nexp++;
        if (s_convert) begin
          nconv++;
          if (int'(s_ramp) > maxr) maxr = int'(s_ramp);
        end
        if (s_read) begin
          nread++;
          if (have && pcol == 2 && s_col == 2'd0 &&
              int'(s_row) == prow + 1)
            wrap = 1'b1;
          have = 1'b1;
          prow = int'(s_row);
          pcol = int'(s_col);
        end
        if (s_done) begin
          len          = i;
          busy_at_done = s_busy;
          break;
        end
      end
      check($sformatf("small[%0d] len", v), 32'(len), 32'(tbl[v].len));
      check($sformatf("small[%0d] read", v), 32'(nread),
            32'(tbl[v].nread));
      check($sformatf("small[%0d] conv", v), 32'(nconv),
            32'(tbl[v].nconv));
      check($sformatf("small[%0d] erase", v), 32'(nerase),
            32'(tbl[v].nerase));
      check($sformatf("small[%0d] expose", v), 32'(nexp),
            32'(tbl[v].nexp));
      check($sformatf("small[%0d] ramp max", v), 32'(maxr),
            32'(tbl[v].maxr));
      check($sformatf("small[%0d] col wrap", v), 32'(wrap), 32'd1);
      check($sformatf("small[%0d] busy at done", v),
            32'(busy_at_done), 32'd0);
      repeat (3) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
